// File: rtl/regfile_scoreboard.sv
// Register file with an in-flight writer scoreboard: per-register busy bits,
// issue stall detection (RAW/WAW), writeback bypass, flush and a spurious-writeback flag.
module regfile_scoreboard #(
   parameter  int WIDTH    = 32,
   parameter  int NUM_REGS = 32,
   parameter  int NUM_RD   = 2,
   localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_RD*IDX_W-1:0]   src_idx,
   input  logic [NUM_RD-1:0]         src_use,
   output logic [NUM_RD*WIDTH-1:0]   src_data,
   output logic [NUM_RD-1:0]         src_busy,
   input  logic                      issue_valid,
   input  logic [IDX_W-1:0]          issue_rd,
   output logic                      stall,
   input  logic                      wb_valid,
   input  logic [IDX_W-1:0]          wb_rd,
   input  logic [WIDTH-1:0]          wb_data,
   input  logic                      flush,
   output logic [NUM_REGS-1:0]       busy_vec,
   output logic [IDX_W:0]            pending_cnt,
   output logic                      err_spurious
);

   localparam int IDX_SPAN = 1 << IDX_W;

   logic [WIDTH-1:0]    r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [IDX_W:0]      r_pending_cnt;
   logic                r_err_spurious;

   logic [IDX_SPAN-1:0] w_busy_ext;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [NUM_RD-1:0]   w_raw;
   logic                w_wb_en;
   logic                w_wb_ok;
   logic                w_iss_ok;
   logic                w_clr;
   logic                w_set;
   logic                w_waw;
   logic                w_accept;
   logic                w_inc;
   logic                w_dec;
   logic                w_spur;

   // Busy bits widened to the full index space so any index reads a defined 0.
   always_comb begin
      w_busy_ext                = '0;
      w_busy_ext[NUM_REGS-1:0]  = r_busy;
   end

   // Everything that modifies state is ignored while reset is held.
   assign w_wb_en  = wb_valid & ~rst;
   assign w_wb_ok  = (wb_rd != '0) && (int'(wb_rd) < NUM_REGS);
   assign w_iss_ok = (issue_rd != '0) && (int'(issue_rd) < NUM_REGS);
   assign w_clr    = w_wb_en & w_wb_ok;

   genvar g;
   generate
      for (g = 0; g < NUM_RD; g++) begin : g_rd
         logic [IDX_W-1:0] w_idx;
         logic             w_hit;
         logic [WIDTH-1:0] w_reg;

         assign w_idx = src_idx[g*IDX_W +: IDX_W];
         assign w_hit = w_wb_en && (wb_rd == w_idx);
         assign w_reg = (int'(w_idx) < NUM_REGS) ? r_regs[w_idx] : '0;

         assign src_data[g*WIDTH +: WIDTH] = (w_idx == '0) ? '0 :
                                             (w_hit ? wb_data : w_reg);
         assign src_busy[g] = w_busy_ext[w_idx] & ~w_hit;
         assign w_raw[g]    = src_use[g] & src_busy[g];
      end
   endgenerate

   // A same-cycle writeback to the destination retires the old writer in time.
   assign w_waw    = w_iss_ok && w_busy_ext[issue_rd] &&
                     !(w_wb_en && (wb_rd == issue_rd));
   assign stall    = issue_valid & ~flush & ~rst & ((|w_raw) | w_waw);
   assign w_accept = issue_valid & ~flush & ~rst & ~stall;
   assign w_set    = w_accept & w_iss_ok;

   // Count bookkeeping: a set on an already-busy register only happens when the
   // same-cycle writeback cleared it, so the net change is zero.
   assign w_inc  = w_set && !w_busy_ext[issue_rd];
   assign w_dec  = w_clr && w_busy_ext[wb_rd] && !(w_set && (issue_rd == wb_rd));
   assign w_spur = w_clr && !w_busy_ext[wb_rd] && !flush;

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_clr) begin
         w_busy_nxt[wb_rd] = 1'b0;
      end
      if (w_set) begin
         w_busy_nxt[issue_rd] = 1'b1;
      end
      if (flush) begin
         w_busy_nxt = '0;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy         <= '0;
         r_pending_cnt  <= '0;
         r_err_spurious <= 1'b0;
      end else begin
         if (w_clr) begin
            r_regs[wb_rd] <= wb_data;
         end
         r_busy <= w_busy_nxt;
         if (flush) begin
            r_pending_cnt <= '0;
         end else begin
            r_pending_cnt <= r_pending_cnt + {{IDX_W{1'b0}}, w_inc}
                                           - {{IDX_W{1'b0}}, w_dec};
         end
         if (w_spur) begin
            r_err_spurious <= 1'b1;
         end
      end
   end

   assign busy_vec     = r_busy;
   assign pending_cnt  = r_pending_cnt;
   assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, flush and async-reset
// sequences, then random traffic checked against an array-based reference model.
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst;
   logic [9:0]  src_idx;
   logic [1:0]  src_use;
   logic [63:0] src_data;
   logic [1:0]  src_busy;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic [31:0] busy_vec;
   logic [5:0]  pending_cnt;
   logic        err_spurious;

   int n_total = 0;
   int n_pass  = 0;

   regfile_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .src_idx      (src_idx),
      .src_use      (src_use),
      .src_data     (src_data),
      .src_busy     (src_busy),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .stall        (stall),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .flush        (flush),
      .busy_vec     (busy_vec),
      .pending_cnt  (pending_cnt),
      .err_spurious (err_spurious)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: plain arrays updated from the architectural rules
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   bit          m_err;

   function automatic logic [31:0] exp_rd(input logic [4:0] idx);
      if (rst || idx == 0) return 32'h0;
      if (wb_valid && wb_rd == idx) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic logic exp_sbusy(input logic [4:0] idx);
      if (rst) return 1'b0;
      return m_busy[idx] && !(wb_valid && wb_rd == idx);
   endfunction

   function automatic logic exp_stall();
      logic raw;
      logic waw;
      if (!issue_valid || flush || rst) return 1'b0;
      raw = (src_use[0] && exp_sbusy(src_idx[4:0])) || (src_use[1] && exp_sbusy(src_idx[9:5]));
      waw = (issue_rd != 0) && exp_sbusy(issue_rd);
      return raw || waw;
   endfunction

   function automatic logic [31:0] exp_bvec();
      logic [31:0] v = '0;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic logic [5:0] exp_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += m_busy[i] ? 1 : 0;
      return 6'(c);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] <= 32'h0;
            m_busy[i] <= 1'b0;
         end
         m_err <= 1'b0;
      end else begin
         if (wb_valid && wb_rd != 0) begin
            if (!m_busy[wb_rd] && !flush) m_err <= 1'b1;
            m_regs[wb_rd] <= wb_data;
         end
         if (wb_valid) m_busy[wb_rd] <= 1'b0;
         if (issue_valid && !flush && !exp_stall() && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
         if (flush) for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      end
   end

   // scoreboard comparison
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // driver
   task automatic set_in(input logic iv, input logic [4:0] ird, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [1:0] su, input logic wv,
                         input logic [4:0] wrd, input logic [31:0] wd, input logic fl);
      issue_valid = iv;
      issue_rd    = ird;
      src_idx     = {s1, s0};
      src_use     = su;
      wb_valid    = wv;
      wb_rd       = wrd;
      wb_data     = wd;
      flush       = fl;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  s0;
      logic [4:0]  s1;
      logic [1:0]  su;
      logic        wv;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic        e_stall;
      logic [1:0]  e_sbusy;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [31:0] e_bvec;
      logic [5:0]  e_cnt;
      logic        e_err;
   } vec_t;

   vec_t vecs [9];

   initial begin
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;

      vecs[0] = '{1, 5, 0, 0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 32'h0,        32'h0,        32'h20, 1, 0};
      vecs[1] = '{1, 6, 5, 0, 2'b01, 0, 0, 32'h0,        1, 2'b01, 32'h0,        32'h0,        32'h20, 1, 0};
      vecs[2] = '{1, 0, 0, 5, 2'b10, 1, 5, 32'hDEADBEEF, 0, 2'b00, 32'h0,        32'hDEADBEEF, 32'h0,  0, 0};
      vecs[3] = '{1, 7, 5, 0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 32'hDEADBEEF, 32'h0,        32'h80, 1, 0};
      vecs[4] = '{1, 7, 7, 0, 2'b00, 0, 0, 32'h0,        1, 2'b01, 32'h0,        32'h0,        32'h80, 1, 0};
      vecs[5] = '{1, 7, 7, 5, 2'b00, 1, 7, 32'h77,       0, 2'b00, 32'h77,       32'hDEADBEEF, 32'h80, 1, 0};
      vecs[6] = '{0, 0, 7, 0, 2'b00, 1, 7, 32'h99,       0, 2'b00, 32'h99,       32'h0,        32'h0,  0, 0};
      vecs[7] = '{1, 0, 0, 7, 2'b11, 1, 0, 32'h1234,     0, 2'b00, 32'h0,        32'h99,       32'h0,  0, 0};
      vecs[8] = '{0, 0, 0, 7, 2'b00, 0, 0, 32'h0,        0, 2'b00, 32'h0,        32'h99,       32'h0,  0, 0};

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_busy_vec", busy_vec, 0);
      check("rst_cnt", pending_cnt, 0);
      check("rst_err", err_spurious, 0);
      next_edge();
      rst = 1'b0;

      // directed vector table
      for (int r = 0; r < 9; r++) begin
         set_in(vecs[r].iv, vecs[r].ird, vecs[r].s0, vecs[r].s1, vecs[r].su,
                vecs[r].wv, vecs[r].wrd, vecs[r].wd, 0);
         @(negedge clk);
         check($sformatf("v%0d_stall", r), stall, vecs[r].e_stall);
         check($sformatf("v%0d_src_busy", r), src_busy, vecs[r].e_sbusy);
         check($sformatf("v%0d_d0", r), src_data[31:0], vecs[r].e_d0);
         check($sformatf("v%0d_d1", r), src_data[63:32], vecs[r].e_d1);
         next_edge();
         check($sformatf("v%0d_busy_vec", r), busy_vec, vecs[r].e_bvec);
         check($sformatf("v%0d_cnt", r), pending_cnt, vecs[r].e_cnt);
         check($sformatf("v%0d_err", r), err_spurious, vecs[r].e_err);
      end

      // flush with same-cycle issue and writeback
      set_in(1, 3, 0, 0, 0, 0, 0, 0, 0);
      next_edge();
      set_in(1, 4, 0, 0, 0, 0, 0, 0, 0);
      next_edge();
      set_in(1, 9, 0, 0, 0, 0, 0, 0, 0);
      next_edge();
      check("pre_flush_busy", busy_vec, 32'h218);
      check("pre_flush_cnt", pending_cnt, 3);
      set_in(1, 10, 10, 0, 2'b01, 1, 3, 32'h55, 1);
      @(negedge clk);
      check("flush_stall", stall, 0);
      next_edge();
      check("flush_busy_vec", busy_vec, 0);
      check("flush_cnt", pending_cnt, 0);
      check("flush_err", err_spurious, 0);
      set_in(0, 0, 3, 10, 2'b11, 1, 4, 32'h1, 0);
      @(negedge clk);
      check("flush_reg3", src_data[31:0], 32'h55);
      check("flush_reg10_busy", src_busy[1], 0);
      next_edge();
      check("spurious_err", err_spurious, 1);

      // asynchronous reset between edges
      set_in(1, 2, 0, 0, 0, 0, 0, 0, 0);
      next_edge();
      set_in(1, 11, 0, 0, 0, 0, 0, 0, 0);
      next_edge();
      check("pre_rst_busy", busy_vec, 32'h804);
      check("pre_rst_cnt", pending_cnt, 2);
      set_in(1, 2, 3, 5, 2'b11, 1, 3, 32'hAAAA, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_busy_vec", busy_vec, 0);
      check("arst_cnt", pending_cnt, 0);
      check("arst_err", err_spurious, 0);
      check("arst_reads", src_data, 64'h0);
      check("arst_stall", stall, 0);
      next_edge();
      check("arst_hold_reads", src_data, 64'h0);
      check("arst_hold_busy", busy_vec, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // random traffic against the reference model
      for (int c = 0; c < 400; c++) begin
         set_in($urandom_range(0, 9) < 7,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 19) == 0);
         @(negedge clk);
         check("rnd_stall", stall, exp_stall());
         check("rnd_src_busy", src_busy, {exp_sbusy(src_idx[9:5]), exp_sbusy(src_idx[4:0])});
         check("rnd_d0", src_data[31:0], exp_rd(src_idx[4:0]));
         check("rnd_d1", src_data[63:32], exp_rd(src_idx[9:5]));
         next_edge();
         check("rnd_busy_vec", busy_vec, exp_bvec());
         check("rnd_cnt", pending_cnt, exp_cnt());
         check("rnd_err", err_spurious, m_err);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32: register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count; IDX_W = ceil(log2(NUM_REGS)).
REQ-003 SHALL have parameter NUM_RD, default 2: number of read/source ports.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port src_idx  in  NUM_RD*IDX_W  packed source register indices; port i at bits [i*IDX_W +: IDX_W].
REQ-007 SHALL have port src_use  in  NUM_RD  source port i actually needed by the issuing instruction.
REQ-008 SHALL have port src_data  out  NUM_RD*WIDTH  packed read data, port i at [i*WIDTH +: WIDTH].
REQ-009 SHALL have port src_busy  out  NUM_RD  source i has an unresolved pending writer.
REQ-010 SHALL have port issue_valid  in  1  an instruction requests issue this cycle.
REQ-011 SHALL have port issue_rd  in  IDX_W  destination of the issuing instruction.
REQ-012 SHALL have port stall  out  1  issue refused this cycle.
REQ-013 SHALL have port wb_valid  in  1  writeback this cycle.
REQ-014 SHALL have port wb_rd  in  IDX_W  writeback destination.
REQ-015 SHALL have port wb_data  in  WIDTH  writeback value.
REQ-016 SHALL have port flush  in  1  squash all in-flight writers.
REQ-017 SHALL have port busy_vec  out  NUM_REGS  registered busy bit per register.
REQ-018 SHALL have port pending_cnt  out  IDX_W+1  registered count of set busy bits.
REQ-019 SHALL have port err_spurious  out  1  sticky: writeback seen to a non-busy register.

Function
REQ-020 SHALL hold NUM_REGS x WIDTH storage; register 0 reads 0, ignores writes, never becomes busy.
REQ-021 SHALL write wb_data into wb_rd on the clock edge when wb_valid=1 and wb_rd!=0.
REQ-022 SHALL produce src_data combinationally; when wb_valid=1, wb_rd=src_idx[i], wb_rd!=0, SHALL bypass wb_data (zero-latency write-through).
REQ-023 SHALL drive src_busy[i] = busy[src_idx[i]] AND NOT (wb_valid AND wb_rd=src_idx[i]).
REQ-024 SHALL assert stall combinationally when issue_valid=1 and either any src_use[i]&src_busy[i] (RAW) or issue_rd!=0 with busy[issue_rd] not cleared by same-cycle writeback (WAW); stall=0 when issue_valid=0 or flush=1.
REQ-025 SHALL accept issue when issue_valid=1, stall=0, flush=0; accepted issue with issue_rd!=0 sets busy[issue_rd] at the edge.
REQ-026 SHALL clear busy[wb_rd] at the edge on wb_valid=1; if an accepted issue targets the same register in the same cycle, set SHALL win.
REQ-027 SHALL clear all busy bits at the edge when flush=1, discard any same-cycle issue, still perform same-cycle writeback data write; register contents otherwise preserved.
REQ-028 SHALL keep pending_cnt equal to popcount(busy_vec) after every edge (+1 on set, -1 on clear, unchanged on set+clear of same reg, 0 after flush).
REQ-029 SHALL set err_spurious at the edge when wb_valid=1, wb_rd!=0, busy[wb_rd]=0 and flush=0; data still written; cleared only by reset.

Reset
REQ-030 SHALL on rst=1 immediately clear all registers to 0, busy_vec to 0, pending_cnt to 0, err_spurious to 0, independent of clk.
REQ-031 SHALL, while rst=1, ignore issue, writeback and flush; outputs reflect the reset state.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-033 Issue rd=5 (accepted), next cycle issue with src0=5,src_use=01 -> stall=1, src_busy[0]=1, pending_cnt=1.
REQ-034 busy[5]=1, same cycle wb_valid rd=5 data=0xDEADBEEF and read src1=5 -> src_data[1]=0xDEADBEEF, src_busy[1]=0, stall=0; next cycle busy[5]=0, pending_cnt=0.
REQ-035 Issue rd=7 while busy[7]=1 and no writeback -> stall=1; repeat with wb rd=7 same cycle -> stall=0, busy[7]=1 after edge, pending_cnt unchanged.
REQ-036 Issue rd=0 and wb rd=0 data=0x1234 -> busy_vec[0]=0, read of reg 0 returns 0, pending_cnt=0, err_spurious=0.
REQ-037 Busy regs 3,4,9, flush with issue rd=10 and wb rd=3 data=0x55 -> busy_vec=0, pending_cnt=0, reg3=0x55, reg10 not busy; later wb rd=4 -> err_spurious=1.
REQ-038 Assert rst mid-run between edges with busy regs set -> busy_vec=0, pending_cnt=0, all reads 0 before next edge.
